// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU: opcodes, FSM states and instruction fields.
package cpu_pkg;

    localparam logic [3:0] OpMov  = 4'h0;
    localparam logic [3:0] OpAdd  = 4'h1;
    localparam logic [3:0] OpSub  = 4'h2;
    localparam logic [3:0] OpMul  = 4'h3;
    localparam logic [3:0] OpIn   = 4'h7;
    localparam logic [3:0] OpOut  = 4'h8;
    localparam logic [3:0] OpStop = 4'hF;

    localparam int unsigned OpLsb = 12;
    localparam int unsigned ALsb  = 8;
    localparam int unsigned BLsb  = 4;
    localparam int unsigned CLsb  = 0;

    // Operand nibble: bit 3 selects indirect addressing, bits 2:0 give the base address.
    localparam int unsigned IndBit = 3;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StRdPtr,
        StRdData,
        StWrPtr,
        StWrite,
        StInWait,
        StOutWait,
        StHalt
    } state_t;

    typedef enum logic [1:0] {
        FldA,
        FldB,
        FldC
    } fld_t;

    function automatic logic [3:0] operand_nib(input logic [15:0] ir, input fld_t fld);
        logic [3:0] nib;
        case (fld)
            FldB:    nib = ir[BLsb +: 4];
            FldC:    nib = ir[CLsb +: 4];
            default: nib = ir[ALsb +: 4];
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational datapath for MOV/ADD/SUB/MUL; unlisted opcodes pass operand a through.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic [3:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] result
);

    always_comb begin
        result = a;
        case (op)
            OpAdd:   result = a + b;
            OpSub:   result = a - b;
            OpMul:   result = a * b;
            default: result = a;
        endcase
    end

endmodule

// File: rtl/cpu_multicycle.sv
// Multicycle CPU core: fetches 16-bit instructions and executes them one memory access per cycle.
module cpu_multicycle
    import cpu_pkg::*;
#(
    parameter int unsigned          ADDR_WIDTH = 6,
    parameter int unsigned          DATA_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] PC_INIT   = 8,
    parameter logic [ADDR_WIDTH-1:0] SP_INIT   = {ADDR_WIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] mem_in,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] sp,
    output logic                  halted
);

    state_t                state;
    fld_t                  fld;
    logic                  deref;
    logic [15:0]           ir;
    logic [DATA_WIDTH-1:0] opb;
    logic [DATA_WIDTH-1:0] opc;
    logic [DATA_WIDTH-1:0] alu_res;
    logic [3:0]            cur_nib;
    logic [3:0]            a_nib;
    logic [ADDR_WIDTH-1:0] cur_x;
    logic [ADDR_WIDTH-1:0] a_x;
    logic [ADDR_WIDTH-1:0] mem_ptr;
    state_t                dest_state;

    assign cur_nib    = operand_nib(ir, fld);
    assign a_nib      = operand_nib(ir, FldA);
    assign cur_x      = {{(ADDR_WIDTH-3){1'b0}}, cur_nib[2:0]};
    assign a_x        = {{(ADDR_WIDTH-3){1'b0}}, a_nib[2:0]};
    assign mem_ptr    = mem_in[ADDR_WIDTH-1:0];
    assign dest_state = a_nib[IndBit] ? StWrPtr : StWrite;

    cpu_alu #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_alu (
        .op    (ir[OpLsb +: 4]),
        .a     (opb),
        .b     (opc),
        .result(alu_res)
    );

    // Memory/handshake strobes are forced idle while reset is asserted.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        in_ready = 1'b0;
        if (!rst) begin
            case (state)
                StFetch:  mem_addr = pc;
                StRdPtr:  mem_addr = deref ? mem_ptr : cur_x;
                StWrPtr:  mem_addr = a_x;
                StWrite: begin
                    mem_we   = 1'b1;
                    mem_addr = a_nib[IndBit] ? mem_ptr : a_x;
                    mem_data = alu_res;
                end
                StInWait: in_ready = 1'b1;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StFetch;
            fld       <= FldB;
            deref     <= 1'b0;
            pc        <= PC_INIT;
            sp        <= SP_INIT;
            ir        <= '0;
            opb       <= '0;
            opc       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            halted    <= 1'b0;
        end else begin
            // A load later in this block overrides the consume-clear.
            if (out_ready) out_valid <= 1'b0;
            case (state)
                StFetch: begin
                    pc    <= pc + ADDR_WIDTH'(1);
                    state <= StDecode;
                end
                StDecode: begin
                    ir    <= mem_in[15:0];
                    fld   <= FldB;
                    deref <= 1'b0;
                    case (mem_in[OpLsb +: 4])
                        OpMov, OpAdd, OpSub, OpMul: state <= StRdPtr;
                        OpIn:                       state <= StInWait;
                        OpOut: begin
                            fld   <= FldA;
                            state <= StRdPtr;
                        end
                        OpStop: begin
                            halted <= 1'b1;
                            state  <= StHalt;
                        end
                        default: state <= StFetch;
                    endcase
                end
                StRdPtr: begin
                    if (!deref && cur_nib[IndBit]) begin
                        deref <= 1'b1;
                    end else begin
                        deref <= 1'b0;
                        state <= StRdData;
                    end
                end
                StRdData: begin
                    case (fld)
                        FldB: begin
                            opb <= mem_in;
                            if (ir[OpLsb +: 4] == OpMov) begin
                                state <= dest_state;
                            end else begin
                                fld   <= FldC;
                                state <= StRdPtr;
                            end
                        end
                        FldC: begin
                            opc   <= mem_in;
                            state <= dest_state;
                        end
                        default: begin
                            if (out_valid && !out_ready) begin
                                opb   <= mem_in;
                                state <= StOutWait;
                            end else begin
                                out       <= mem_in;
                                out_valid <= 1'b1;
                                state     <= StFetch;
                            end
                        end
                    endcase
                end
                StWrPtr: state <= StWrite;
                StWrite: state <= StFetch;
                StInWait: begin
                    if (in_valid) begin
                        opb   <= in;
                        state <= dest_state;
                    end
                end
                StOutWait: begin
                    if (out_ready) begin
                        out       <= opb;
                        out_valid <= 1'b1;
                        state     <= StFetch;
                    end
                end
                default: state <= StHalt;
            endcase
        end
    end

endmodule
